// File: rtl/dpe_quiesce_ctrl.sv
// dpe_quiesce_ctrl
// Quiesces the DPE pipeline so the CPU can update its tables safely. On request,
// the controller pauses the input multiplexer and waits for it to park. It then
// drains in-flight packets and holds off for a settle period before granting the
// update window. A nonzero timeout aborts the request if the PAUSE+DRAIN wait
// runs too long.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   cfg_req / cfg_done    CPU request level / update-finished pulse
//   cfg_gnt / cfg_abort   window granted / request aborted (levels)
//   mux_pause             pause input of the DPE multiplexer
//   mux_is_idle           multiplexer parked and empty
//   pkt_enter / pkt_exit  tlast accepted at DPE input / output
//   timeout_cfg           max PAUSE+DRAIN wait cycles, 0 = no timeout
//   timeout_err           sticky timeout flag
//   inflight              packets currently inside the DPE
//   state                 current FSM state code
module dpe_quiesce_ctrl #(
  parameter int unsigned INFLIGHT_W = 8,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cfg_req,
  input  logic                  cfg_done,
  output logic                  cfg_gnt,
  output logic                  cfg_abort,
  output logic                  mux_pause,
  input  logic                  mux_is_idle,
  input  logic                  pkt_enter,
  input  logic                  pkt_exit,
  input  logic [15:0]           timeout_cfg,
  output logic                  timeout_err,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StPause   = 3'd1,
    StDrain   = 3'd2,
    StSettle  = 3'd3,
    StGrant   = 3'd4,
    StRelease = 3'd5,
    StAbort   = 3'd6
  } state_e;

  localparam logic [INFLIGHT_W-1:0] InflMax   = '1;
  localparam logic [7:0]            SettleEnd = 8'(SETTLE_CYC - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [15:0]           r_wait;
  logic [7:0]            r_settle;
  logic [INFLIGHT_W-1:0] r_inflight;
  logic [INFLIGHT_W-1:0] w_inflight_next;
  logic                  r_timeout_err;
  logic                  w_timeout_hit;

  assign w_timeout_hit = (timeout_cfg != 16'd0) && (r_wait == timeout_cfg - 16'd1);

  // Next-state logic; the cancel check (cfg_req low) takes priority over the timeout.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:     if (cfg_req) w_state_next = StPause;
      StPause: begin
        if (!cfg_req)          w_state_next = StRelease;
        else if (w_timeout_hit) w_state_next = StAbort;
        else if (mux_is_idle)  w_state_next = StDrain;
      end
      StDrain: begin
        if (!cfg_req)                    w_state_next = StRelease;
        else if (w_timeout_hit)          w_state_next = StAbort;
        else if (r_inflight == '0)       w_state_next = StSettle;
      end
      StSettle: begin
        if (!cfg_req)                    w_state_next = StRelease;
        else if (r_settle == SettleEnd)  w_state_next = StGrant;
      end
      StGrant:   if (cfg_done || !cfg_req) w_state_next = StRelease;
      StRelease: w_state_next = StRun;
      StAbort:   if (!cfg_req) w_state_next = StRun;
      // Code 7 is unreachable in normal operation; recover to RUN.
      default:   w_state_next = StRun;
    endcase
  end

  // Simultaneous enter and exit cancel out; both directions saturate.
  always_comb begin
    w_inflight_next = r_inflight;
    if (pkt_enter && !pkt_exit && (r_inflight != InflMax)) begin
      w_inflight_next = r_inflight + 1'b1;
    end else if (pkt_exit && !pkt_enter && (r_inflight != '0)) begin
      w_inflight_next = r_inflight - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= StRun;
      r_wait        <= 16'd0;
      r_settle      <= 8'd0;
      r_inflight    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_inflight_next;
      if ((r_state == StPause) || (r_state == StDrain)) begin
        if (r_wait != 16'hffff) r_wait <= r_wait + 16'd1;
      end else begin
        r_wait <= 16'd0;
      end
      r_settle <= (r_state == StSettle) ? r_settle + 8'd1 : 8'd0;
      if ((w_state_next == StAbort) && (r_state != StAbort)) r_timeout_err <= 1'b1;
    end
  end

  // Outputs decode the state register only.
  assign mux_pause   = (r_state == StPause) || (r_state == StDrain) ||
                       (r_state == StSettle) || (r_state == StGrant);
  assign cfg_gnt     = (r_state == StGrant);
  assign cfg_abort   = (r_state == StAbort);
  assign timeout_err = r_timeout_err;
  assign inflight    = r_inflight;
  assign state       = r_state;

endmodule

// File: tb/tb_dpe_quiesce_ctrl.sv
// Self-checking bench for dpe_quiesce_ctrl. Each scenario pushes its expected
// per-cycle observation {state, mux_pause, cfg_gnt, cfg_abort, timeout_err,
// inflight} to a queue, then drives one cycle at a time and pops/compares.
module tb_dpe_quiesce_ctrl;

  localparam int unsigned IW = 2;
  localparam int unsigned SC = 4;
  localparam logic [2:0] RUN = 3'd0, PAUSE = 3'd1, DRAIN = 3'd2, SETTLE = 3'd3;
  localparam logic [2:0] GRANT = 3'd4, RELEASE = 3'd5, ABORT = 3'd6;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          cfg_req, cfg_done, mux_is_idle, pkt_enter, pkt_exit;
  logic [15:0]   timeout_cfg;
  logic          cfg_gnt, cfg_abort, mux_pause, timeout_err;
  logic [IW-1:0] inflight;
  logic [2:0]    state;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs;
  logic [8:0] want;
  logic       terr_exp = 1'b0;

  assign obs = {state, mux_pause, cfg_gnt, cfg_abort, timeout_err, inflight};

  always #5 sys_clk = ~sys_clk;

  dpe_quiesce_ctrl #(
    .INFLIGHT_W(IW),
    .SETTLE_CYC(SC)
  ) u_dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cfg_req    (cfg_req),
    .cfg_done   (cfg_done),
    .cfg_gnt    (cfg_gnt),
    .cfg_abort  (cfg_abort),
    .mux_pause  (mux_pause),
    .mux_is_idle(mux_is_idle),
    .pkt_enter  (pkt_enter),
    .pkt_exit   (pkt_exit),
    .timeout_cfg(timeout_cfg),
    .timeout_err(timeout_err),
    .inflight   (inflight),
    .state      (state)
  );

  // Expected observation word from the state code using the output table.
  function automatic logic [8:0] mk(input logic [2:0] st, input logic terr,
                                    input logic [1:0] infl);
    logic p, g, a;
    p = (st == PAUSE) || (st == DRAIN) || (st == SETTLE) || (st == GRANT);
    g = (st == GRANT);
    a = (st == ABORT);
    return {st, p, g, a, terr, infl};
  endfunction

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; cfg_req = 1'b1; cfg_done = 1'b1; mux_is_idle = 1'b1;
    pkt_enter = 1'b1; pkt_exit = 1'b0; timeout_cfg = 16'd1;
    exp_q.push_back(mk(RUN, 1'b0, 2'd0));
    exp_q.push_back(mk(RUN, 1'b0, 2'd0));
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        sys_rst = 1'b0; cfg_req = 1'b0; cfg_done = 1'b0; pkt_enter = 1'b0;
        timeout_cfg = 16'd0;
      end
      cyc();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
        n_err++; $display("FAIL reset[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

  // Grant at cycle 7 after cfg_req at cycle 0; cfg_done releases; req still high
  // in RELEASE must not skip RUN.
  task automatic test_nominal();
    logic [2:0] seq[11];
    seq = '{PAUSE, DRAIN, SETTLE, SETTLE, SETTLE, SETTLE, GRANT, GRANT, RELEASE, RUN, RUN};
    mux_is_idle = 1'b1; timeout_cfg = 16'd0;
    for (int i = 0; i < 11; i++) exp_q.push_back(mk(seq[i], terr_exp, 2'd0));
    for (int i = 0; i < 11; i++) begin
      cfg_req  = (i < 10);
      cfg_done = (i == 8) || (i == 3);
      cyc();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
        n_err++; $display("FAIL nominal[%0d]: got %b want %b", i, obs, want);
      end
    end
    cfg_done = 1'b0; cfg_req = 1'b0;
  endtask

  // Drain waits on the counter only; enter+exit together leave inflight alone.
  task automatic test_drain();
    logic [11:0] en   = 12'b000000100111;
    logic [11:0] ex   = 12'b000111100000;
    logic [11:0] rq   = 12'b001111111000;
    logic [11:0] dn   = 12'b000001000000;
    logic [11:0] idl  = 12'b110000011111;
    logic [2:0]  st[12];
    logic [1:0]  inf[12];
    st  = '{RUN, RUN, RUN, PAUSE, DRAIN, DRAIN, DRAIN, DRAIN, DRAIN, SETTLE, RELEASE, RUN};
    inf = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 12; i++) exp_q.push_back(mk(st[i], terr_exp, inf[i]));
    for (int i = 0; i < 12; i++) begin
      pkt_enter = en[i]; pkt_exit = ex[i]; cfg_req = rq[i]; cfg_done = dn[i];
      mux_is_idle = idl[i];
      cyc();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
        n_err++; $display("FAIL drain[%0d]: got %b want %b", i, obs, want);
      end
    end
    pkt_enter = 1'b0; pkt_exit = 1'b0; cfg_done = 1'b0; mux_is_idle = 1'b1;
  endtask

  task automatic test_cancel();
    logic [2:0] st[7];
    logic [6:0] rq = 7'b0101111;
    st = '{PAUSE, DRAIN, SETTLE, SETTLE, RELEASE, RUN, RUN};
    mux_is_idle = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(st[i], terr_exp, 2'd0));
    for (int i = 0; i < 7; i++) begin
      cfg_req = rq[i];
      cyc();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
        n_err++; $display("FAIL cancel[%0d]: got %b want %b", i, obs, want);
      end
    end
    cfg_req = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] inf[9];
    inf = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 9; i++) exp_q.push_back(mk(RUN, terr_exp, inf[i]));
    for (int i = 0; i < 9; i++) begin
      pkt_enter = (i < 5); pkt_exit = (i >= 5);
      cyc();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
        n_err++; $display("FAIL saturation[%0d]: got %b want %b", i, obs, want);
      end
    end
    pkt_enter = 1'b0; pkt_exit = 1'b0;
  endtask

  // PAUSE entered after step 0; ABORT exactly 10 cycles later.
  task automatic test_timeout();
    mux_is_idle = 1'b0; timeout_cfg = 16'd10;
    for (int i = 0; i < 15; i++) begin
      if (i < 10)      exp_q.push_back(mk(PAUSE, 1'b0, 2'd0));
      else if (i < 13) exp_q.push_back(mk(ABORT, 1'b1, 2'd0));
      else             exp_q.push_back(mk(RUN, 1'b1, 2'd0));
    end
    for (int i = 0; i < 15; i++) begin
      cfg_req = (i < 13);
      cyc();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
        n_err++; $display("FAIL timeout[%0d]: got %b want %b", i, obs, want);
      end
    end
    terr_exp = 1'b1; cfg_req = 1'b0; mux_is_idle = 1'b1; timeout_cfg = 16'd0;
  endtask

  // Reset in GRANT returns straight to RUN with all flags cleared, no RELEASE.
  task automatic test_reset_grant();
    logic [2:0] st[9];
    st = '{PAUSE, DRAIN, SETTLE, SETTLE, SETTLE, SETTLE, GRANT, RUN, RUN};
    mux_is_idle = 1'b1; timeout_cfg = 16'd0;
    for (int i = 0; i < 9; i++) exp_q.push_back(mk(st[i], (i < 7) ? terr_exp : 1'b0, 2'd0));
    for (int i = 0; i < 9; i++) begin
      sys_rst   = (i == 7);
      pkt_enter = (i == 7);
      cfg_req   = (i < 8);
      cyc();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
        n_err++; $display("FAIL reset_grant[%0d]: got %b want %b", i, obs, want);
      end
    end
    terr_exp = 1'b0; sys_rst = 1'b0; pkt_enter = 1'b0; cfg_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_drain();
    test_cancel();
    test_saturation();
    test_timeout();
    test_reset_grant();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
